vector_issue_sequencer: RTL and testbench
=========================================

Name: vector_issue_sequencer

Overview:
Front-end controller for the vector datapath. It accepts 13-bit vector instructions over a valid/ready interface and buffers them in a small FIFO. It pre-checks memory bounds, then issues each instruction to the vector processor's instruction, mem_addr and reg_select inputs for the required number of cycles. The vector processor has no enable, so when nothing is issuing the sequencer drives a guaranteed no-op encoding.

Parameters:
DEPTH, 4, instruction FIFO depth; power of 2, at least 2
MUL_CYCLES, 2, cycles a multiply is held on the datapath (at least 1); all other opcodes are held 1 cycle
CNT_W, 16, width of issued_count

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  FIFO can accept; equals (count < DEPTH) and !flush
in_instr  in  13  [12:11] opcode (00 load, 01 store, 10 add, 11 mul), [10:9] reg_select, [8:0] mem_addr
flush  in  1  synchronous: discard queued and in-flight work
vp_instruction  out  2  to vector processor instruction
vp_reg_select  out  2  to vector processor reg_select
vp_mem_addr  out  9  to vector processor mem_addr
vp_out_of_bound  in  1  vector processor out_of_bound, used for a consistency check
busy  out  1  state != IDLE or FIFO non-empty
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
issued_count  out  CNT_W  instructions issued; wraps
drop_count  out  8  instructions dropped by the bound pre-check; saturates at 255
err_oob  out  1  sticky: at least one instruction dropped
err_mismatch  out  1  sticky: vp_out_of_bound=1 while a legal instruction was issuing
err_clear  in  1  synchronous clear of err_oob, err_mismatch and drop_count

Behaviour:
- NOP encoding: vp_instruction=00, vp_reg_select=00, vp_mem_addr=9'h1FF. Because 511+16 > 512, the datapath suppresses all writes for this encoding.
- Reset (async, rst_n=0): FIFO empty, state IDLE, vp_* = NOP, busy=0, all counters 0, both error flags 0. A reset in the middle of a multiply returns vp_* to NOP immediately.
- All vp_* outputs are registered.
- Push: a transfer occurs when in_valid && in_ready. There is no bypass: a push into an empty FIFO becomes visible for pop on the next edge. A full FIFO gives in_ready=0. Push and pop in the same cycle leave the count unchanged.
- Bound pre-check on the popped word: legal when mem_addr <= 496, i.e. (mem_addr + 16) <= 512 computed at 10 bits. The check applies to all opcodes, matching the datapath gate.
- FSM states: IDLE and EXEC. hold_cnt is the cycle counter.
  - IDLE, FIFO empty: drive NOP and stay in IDLE.
  - IDLE, FIFO non-empty: pop the head.
    - If the head is illegal: increment drop_count, set err_oob, drive NOP, stay in IDLE. The next pop happens on the following edge.
    - If the head is legal: load vp_* with the instruction fields, set hold_cnt = (op==mul ? MUL_CYCLES-1 : 0), increment issued_count, go to EXEC.
  - EXEC with hold_cnt != 0: hold vp_* and decrement hold_cnt.
  - EXEC with hold_cnt == 0, FIFO non-empty: pop the next head and apply the same legal/illegal handling as in IDLE (back-to-back issue; illegal drives NOP and goes to IDLE).
  - EXEC with hold_cnt == 0, FIFO empty: load NOP and go to IDLE.
- Throughput: one non-multiply instruction per cycle in steady state; one multiply per MUL_CYCLES cycles.
- Latency into an empty, idle block: word pushed at edge N is on vp_* from edge N+1 until edge N+2. The datapath commits its write at edge N+2.
- Mismatch check: in EXEC, if vp_out_of_bound=1, set err_mismatch.
- flush priority: flush overrides push and pop. On a flush edge the FIFO empties, vp_* go to NOP, the FSM goes to IDLE and hold_cnt clears. in_ready=0 during the flush cycle, so no word is accepted. Counters are not cleared.
- err_clear: if an error event occurs in the same cycle as err_clear, the set wins (the flag reads 1 and drop_count reads 1).

Decomposition:
- Shared package vec_pkg holds:
  - opcode constants OP_LOAD/OP_STORE/OP_ADD/OP_MUL
  - VEC_WORDS=16, MEM_WORDS=512
  - MAX_LEGAL_ADDR=496
  - NOP_ADDR=9'h1FF
  - instruction field bit positions and INSTR_W=13
- Sub-module vec_instr_fifo: synchronous FIFO with DEPTH, width 13, ports push/pop/flush/count/head. The FSM and counters stay in the top level.

Test Plan:
- Reset then idle -> vp_*={00,00,1FF}, in_ready=1, busy=0, all counters and flags 0.
- Push load r1 @0x010, store r1 @0x020, add back-to-back -> vp_* show each on 3 consecutive cycles, first one edge after its push; issued_count=3.
- Push mul (MUL_CYCLES=2) then load @0x000 -> mul held exactly 2 cycles, load on the 3rd; issued_count=2.
- Push store @0x1F1 (497) then load @0x1F0 (496) -> store never appears on vp_*; drop_count=1, err_oob=1; load issues normally.
- Fill 4 words with the head a mul, hold in_valid -> in_ready=0 at count 4; assert flush mid-mul -> next cycle vp_*=NOP, fifo_count=0, busy=0.
- Force vp_out_of_bound=1 during a legal add -> err_mismatch=1; pulse err_clear -> flags and drop_count return to 0.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector issue sequencer: instruction layout,
// opcodes, memory geometry and the datapath no-op encoding.
package vec_pkg;

  localparam int unsigned INSTR_W  = 13;
  localparam int unsigned OP_MSB   = 12;
  localparam int unsigned OP_LSB   = 11;
  localparam int unsigned RSEL_MSB = 10;
  localparam int unsigned RSEL_LSB = 9;
  localparam int unsigned ADDR_MSB = 8;
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned ADDR_W   = 9;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  localparam int unsigned VEC_WORDS      = 16;
  localparam int unsigned MEM_WORDS      = 512;
  localparam int unsigned MAX_LEGAL_ADDR = 496;

  localparam logic [ADDR_W-1:0] NOP_ADDR = 9'h1FF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } seq_state_e;

  // Bundle driven onto the vector processor inputs
  typedef struct packed {
    logic [1:0]        instruction;
    logic [1:0]        reg_select;
    logic [ADDR_W-1:0] mem_addr;
  } vp_bus_t;

  // 511+16 overruns memory, so the datapath suppresses every write
  localparam vp_bus_t VP_NOP = '{instruction: 2'b00, reg_select: 2'b00, mem_addr: NOP_ADDR};

  // A vector access of VEC_WORDS starting at addr must stay inside memory
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    logic [9:0] span_end;
    span_end = 10'(addr) + 10'(VEC_WORDS);
    return span_end <= 10'(MEM_WORDS);
  endfunction

  // Split a raw instruction word into datapath fields
  function automatic vp_bus_t decode(input logic [INSTR_W-1:0] w);
    vp_bus_t b;
    b.instruction = w[OP_MSB:OP_LSB];
    b.reg_select  = w[RSEL_MSB:RSEL_LSB];
    b.mem_addr    = w[ADDR_MSB:ADDR_LSB];
    return b;
  endfunction

endpackage

// File: rtl/vec_instr_fifo.sv
// Synchronous instruction FIFO; no bypass, flush empties it in one edge.
module vec_instr_fifo
  import vec_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [INSTR_W-1:0]       push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [INSTR_W-1:0]       head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;
  logic               empty;
  logic               do_push;
  logic               do_pop;

  assign full    = count == CNT_W'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vector_issue_sequencer.sv
// Buffers vector instructions, drops out-of-bound accesses and holds each
// legal instruction on the vector processor inputs for its issue time.
module vector_issue_sequencer
  import vec_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     flush,
  output logic [1:0]               vp_instruction,
  output logic [1:0]               vp_reg_select,
  output logic [ADDR_W-1:0]        vp_mem_addr,
  input  logic                     vp_out_of_bound,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         issued_count,
  output logic [7:0]               drop_count,
  output logic                     err_oob,
  output logic                     err_mismatch,
  input  logic                     err_clear
);

  localparam int unsigned FC_W   = $clog2(DEPTH) + 1;
  localparam int unsigned HOLD_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  seq_state_e         state_q, state_d;
  vp_bus_t            vp_q, vp_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   issued_d;
  logic [7:0]         drop_d;
  logic               oob_d;
  logic               mis_d;

  logic [INSTR_W-1:0] head;
  vp_bus_t            head_bus;
  logic               head_legal;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic               slot_free;
  logic               drop_evt;
  logic               mis_evt;

  assign full       = fifo_count == FC_W'(DEPTH);
  assign empty      = fifo_count == '0;
  assign in_ready   = !full && !flush;
  assign push       = in_valid && in_ready;
  assign slot_free  = (state_q == S_IDLE) || (hold_q == '0);
  assign pop        = !flush && !empty && slot_free;
  assign head_bus   = decode(head);
  assign head_legal = addr_legal(head_bus.mem_addr);
  assign drop_evt   = pop && !head_legal;
  assign mis_evt    = (state_q == S_EXEC) && vp_out_of_bound;
  assign busy       = (state_q != S_IDLE) || !empty;

  assign vp_instruction = vp_q.instruction;
  assign vp_reg_select  = vp_q.reg_select;
  assign vp_mem_addr    = vp_q.mem_addr;

  vec_instr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(in_instr),
    .pop      (pop),
    .flush    (flush),
    .count    (fifo_count),
    .head     (head)
  );

  // State, datapath drive and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vp_q         <= VP_NOP;
      hold_q       <= '0;
      issued_count <= '0;
      drop_count   <= '0;
      err_oob      <= 1'b0;
      err_mismatch <= 1'b0;
    end else begin
      state_q      <= state_d;
      vp_q         <= vp_d;
      hold_q       <= hold_d;
      issued_count <= issued_d;
      drop_count   <= drop_d;
      err_oob      <= oob_d;
      err_mismatch <= mis_d;
    end
  end

  // Next-state: issue a legal head, otherwise settle in IDLE
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop && head_legal) state_d = S_EXEC;
        end
        S_EXEC: begin
          if (hold_q == '0) begin
            state_d = (pop && head_legal) ? S_EXEC : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next datapath drive, hold counter, counters and sticky flags
  always_comb begin
    vp_d     = vp_q;
    hold_d   = hold_q;
    issued_d = issued_count;
    drop_d   = drop_count;
    oob_d    = err_oob;
    mis_d    = err_mismatch;

    if (flush) begin
      vp_d   = VP_NOP;
      hold_d = '0;
    end else if (pop) begin
      if (head_legal) begin
        vp_d     = head_bus;
        hold_d   = (head_bus.instruction == OP_MUL) ? HOLD_W'(MUL_CYCLES - 1) : '0;
        issued_d = issued_count + CNT_W'(1);
      end else begin
        vp_d   = VP_NOP;
        hold_d = '0;
      end
    end else if ((state_q == S_EXEC) && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
    end else begin
      vp_d   = VP_NOP;
      hold_d = '0;
    end

    // Clear first so a same-cycle error event still registers
    if (err_clear) begin
      drop_d = '0;
      oob_d  = 1'b0;
      mis_d  = 1'b0;
    end
    if (drop_evt) begin
      oob_d = 1'b1;
      if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
    end
    if (mis_evt) mis_d = 1'b1;
  end

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Directed bench for vector_issue_sequencer with a cycle-stamped scoreboard
// on the vp_* bus and direct checks of status outputs.
module tb_vector_issue_sequencer;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned MUL_CYCLES = 2;
  localparam int unsigned CNT_W      = 16;
  localparam logic [12:0] NOP_W      = 13'h01FF;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [12:0]            in_instr;
  logic                   flush;
  logic [1:0]             vp_instruction;
  logic [1:0]             vp_reg_select;
  logic [8:0]             vp_mem_addr;
  logic                   vp_out_of_bound;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0]       issued_count;
  logic [7:0]             drop_count;
  logic                   err_oob;
  logic                   err_mismatch;
  logic                   err_clear;
  logic [12:0]            vp_obs;

  typedef struct {
    logic [12:0] vp;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  assign vp_obs = {vp_instruction, vp_reg_select, vp_mem_addr};

  vector_issue_sequencer #(
    .DEPTH     (DEPTH),
    .MUL_CYCLES(MUL_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .flush          (flush),
    .vp_instruction (vp_instruction),
    .vp_reg_select  (vp_reg_select),
    .vp_mem_addr    (vp_mem_addr),
    .vp_out_of_bound(vp_out_of_bound),
    .busy           (busy),
    .fifo_count     (fifo_count),
    .issued_count   (issued_count),
    .drop_count     (drop_count),
    .err_oob        (err_oob),
    .err_mismatch   (err_mismatch),
    .err_clear      (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any non-NOP bus value must match the scoreboard head for this cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL vp_missed: cycle %0d expected %h never observed", e.cyc, e.vp);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        tests++;
        if (vp_obs !== e.vp) begin
          fails++;
          $display("FAIL vp_bus: cycle %0d got %h expected %h", cyc, vp_obs, e.vp);
        end
      end else if (vp_obs !== NOP_W) begin
        tests++;
        fails++;
        $display("FAIL vp_unexpected: cycle %0d got %h expected NOP %h", cyc, vp_obs, NOP_W);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one word for one cycle; it should appear on vp_* from cyc+delay for nrep cycles
  task automatic send(input logic [12:0] w, input int delay, input int nrep);
    in_valid = 1'b1;
    in_instr = w;
    for (int k = 0; k < nrep; k++) exp_q.push_back('{vp: w, cyc: cyc + delay + k});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    in_valid        = 1'b0;
    in_instr        = '0;
    flush           = 1'b0;
    vp_out_of_bound = 1'b0;
    err_clear       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Reset / idle state
    chk("rst_vp",       32'(vp_obs),       32'(NOP_W));
    chk("rst_in_ready", 32'(in_ready),     32'd1);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_fifo",     32'(fifo_count),   32'd0);
    chk("rst_issued",   32'(issued_count), 32'd0);
    chk("rst_drop",     32'(drop_count),   32'd0);
    chk("rst_oob",      32'(err_oob),      32'd0);
    chk("rst_mis",      32'(err_mismatch), 32'd0);

    // Back-to-back load, store, add
    send({2'b00, 2'b01, 9'h010}, 2, 1);
    send({2'b01, 2'b01, 9'h020}, 2, 1);
    send({2'b10, 2'b10, 9'h030}, 2, 1);
    idle(4);
    chk("b2b_issued", 32'(issued_count), 32'd3);
    chk("b2b_busy",   32'(busy),         32'd0);

    // Multiply held two cycles, following load on the third
    send({2'b11, 2'b10, 9'h040}, 2, 2);
    send({2'b00, 2'b11, 9'h000}, 3, 1);
    idle(5);
    chk("mul_issued", 32'(issued_count), 32'd5);

    // Address 497 dropped, 496 issued
    send({2'b01, 2'b00, 9'h1F1}, 0, 0);
    send({2'b00, 2'b10, 9'h1F0}, 2, 1);
    idle(4);
    chk("oob_drop",   32'(drop_count),   32'd1);
    chk("oob_flag",   32'(err_oob),      32'd1);
    chk("oob_issued", 32'(issued_count), 32'd6);
    chk("oob_mis",    32'(err_mismatch), 32'd0);

    // Stream of multiplies fills the FIFO, then flush mid-multiply
    send({2'b11, 2'b00, 9'h100}, 2, 2);
    send({2'b11, 2'b01, 9'h101}, 3, 2);
    send({2'b11, 2'b10, 9'h102}, 4, 2);
    send({2'b11, 2'b11, 9'h103}, 5, 1);
    send({2'b11, 2'b00, 9'h104}, 0, 0);
    send({2'b11, 2'b01, 9'h105}, 0, 0);
    send({2'b11, 2'b10, 9'h106}, 0, 0);
    in_valid = 1'b1;
    in_instr = {2'b11, 2'b11, 9'h107};
    #1;
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(in_ready),   32'd0);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_vp",     32'(vp_obs),       32'(NOP_W));
    chk("flush_count",  32'(fifo_count),   32'd0);
    chk("flush_busy",   32'(busy),         32'd0);
    chk("flush_issued", 32'(issued_count), 32'd10);
    chk("flush_drop",   32'(drop_count),   32'd1);
    idle(2);

    // Out-of-bound reported during a legal add, then cleared
    send({2'b10, 2'b00, 9'h050}, 2, 1);
    @(negedge clk);
    chk("mis_before", 32'(err_mismatch), 32'd0);
    vp_out_of_bound = 1'b1;
    @(negedge clk);
    vp_out_of_bound = 1'b0;
    chk("mis_set", 32'(err_mismatch), 32'd1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("clr_oob",    32'(err_oob),      32'd0);
    chk("clr_mis",    32'(err_mismatch), 32'd0);
    chk("clr_drop",   32'(drop_count),   32'd0);
    chk("clr_issued", 32'(issued_count), 32'd11);
    idle(2);

    // Drop of an illegal multiply coincides with err_clear: set wins
    send({2'b11, 2'b01, 9'h1FF}, 0, 0);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("setwin_drop",   32'(drop_count),   32'd1);
    chk("setwin_oob",    32'(err_oob),      32'd1);
    chk("setwin_issued", 32'(issued_count), 32'd11);

    idle(3);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
